// File: rtl/prime_pkg.sv
// Shared types and constants for the prime stream generator.
package prime_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAND,
        DINIT,
        SUB,
        CHECK,
        EMIT,
        FIN
    } state_t;

    localparam int FIRST_PRIME = 2;

endpackage

// File: rtl/prime_stream_gen_if.sv
// Control inputs and prime output stream of prime_stream_gen.
interface prime_stream_gen_if #(
    parameter int W  = 8,
    parameter int CW = 8
);
    logic [W-1:0]  N;
    logic          Start;
    logic [W-1:0]  Prime;
    logic          Valid;
    logic          Ready;
    logic          Busy;
    logic          Done;
    logic [CW-1:0] Count;

    modport master (
        output N, Start, Ready,
        input  Prime, Valid, Busy, Done, Count
    );

    modport slave (
        input  N, Start, Ready,
        output Prime, Valid, Busy, Done, Count
    );
endinterface

// File: rtl/rem_sub_unit.sv
// Remainder register: loads the dividend, then subtracts the divisor
// once per step until the remainder falls below it.
module rem_sub_unit #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         i_load,
    input  logic         i_step,
    input  logic [W-1:0] i_load_val,
    input  logic [W-1:0] i_d,
    output logic         o_lt,
    output logic         o_zero
);
    logic [W-1:0] r_r;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_r <= '0;
        end else if (i_load) begin
            r_r <= i_load_val;
        end else if (i_step && !o_lt) begin
            r_r <= r_r - i_d;
        end
    end

    assign o_lt   = (r_r < i_d);
    assign o_zero = (r_r == '0);
endmodule

// File: rtl/prime_stream_gen.sv
// Enumerates all primes 2..N in ascending order on a valid/ready stream,
// testing each candidate by trial division with repeated subtraction.
module prime_stream_gen #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    prime_stream_gen_if.slave bus
);
    import prime_pkg::*;

    localparam logic [W-1:0] P2 = W'(FIRST_PRIME);

    state_t r_state;
    state_t w_next;

    logic [W-1:0]  r_nl;
    logic [W-1:0]  r_c;
    logic [W-1:0]  r_d;
    logic [W-1:0]  r_prime;
    logic [CW-1:0] r_count;

    logic          w_lt;
    logic          w_zero;
    logic [W:0]    w_d1;

    // a1 start, a2 divisor init, a3 divisor inc, a4 subtract,
    // a5 capture prime, a6 accept, a7 next candidate
    logic w_a1, w_a2, w_a3, w_a4, w_a5, w_a6, w_a7;

    assign w_d1 = {1'b0, r_d} + (W+1)'(1);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_a1   = 1'b0;
        w_a2   = 1'b0;
        w_a3   = 1'b0;
        w_a4   = 1'b0;
        w_a5   = 1'b0;
        w_a6   = 1'b0;
        w_a7   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.Start) begin
                    w_a1   = 1'b1;
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_next = (r_nl < P2) ? FIN : DINIT;
            end
            DINIT: begin
                w_a2 = 1'b1;
                if (r_c == P2) begin
                    w_a5   = 1'b1;
                    w_next = EMIT;
                end else begin
                    w_next = SUB;
                end
            end
            SUB: begin
                w_a4 = 1'b1;
                if (w_lt) w_next = CHECK;
            end
            CHECK: begin
                if (w_zero) begin
                    w_next = CAND;
                end else if (w_d1 == {1'b0, r_c}) begin
                    w_a5   = 1'b1;
                    w_next = EMIT;
                end else begin
                    w_a3   = 1'b1;
                    w_next = SUB;
                end
            end
            EMIT: begin
                if (bus.Ready) begin
                    w_a6   = 1'b1;
                    w_next = CAND;
                end
            end
            // Compare before incrementing so N at full scale never wraps C.
            CAND: begin
                if (r_c == r_nl) begin
                    w_next = FIN;
                end else begin
                    w_a7   = 1'b1;
                    w_next = DINIT;
                end
            end
            FIN: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_nl    <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_prime <= '0;
            r_count <= '0;
        end else begin
            if (w_a1) begin
                r_nl    <= bus.N;
                r_c     <= P2;
                r_count <= '0;
            end
            if (w_a2) r_d <= P2;
            if (w_a3) r_d <= w_d1[W-1:0];
            if (w_a5) r_prime <= r_c;
            if (w_a6 && (r_count != '1)) r_count <= r_count + 1'b1;
            if (w_a7) r_c <= r_c + 1'b1;
        end
    end

    rem_sub_unit #(.W(W)) u_rem (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .i_load     (w_a2 | w_a3),
        .i_step     (w_a4),
        .i_load_val (r_c),
        .i_d        (w_a2 ? P2 : r_d),
        .o_lt       (w_lt),
        .o_zero     (w_zero)
    );

    assign bus.Prime = r_prime;
    assign bus.Valid = (r_state == EMIT);
    assign bus.Busy  = (r_state != IDLE);
    assign bus.Done  = (r_state == FIN);
    assign bus.Count = r_count;
endmodule

// File: tb/tb_prime_stream_gen.sv
// Randomized self-checking bench for prime_stream_gen against a
// trial-division prime list model.
module tb_prime_stream_gen;
    localparam int W  = 8;
    localparam int CW = 8;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;

    prime_stream_gen_if #(.W(W), .CW(CW)) bus ();

    prime_stream_gen #(.W(W), .CW(CW)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int got[$];
    int exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int n);
        exp_q.delete();
        for (int v = 2; v <= n; v++) begin
            bit p = 1'b1;
            for (int k = 2; k * k <= v; k++)
                if (v % k == 0) p = 1'b0;
            if (p) exp_q.push_back(v);
        end
    endfunction

    // mode 0: Ready high, 1: random Ready, 2: Ready low for 20 Valid cycles
    task automatic run(input int n, input int mode, input int restart_at,
                       input int bound, input string tag);
        int cyc = 0;
        int dones = 0;
        int hold = 0;
        int unstable = 0;
        int seen_valid = 0;
        int max_seen = 0;
        logic [W-1:0] held = '0;
        got.delete();
        model(n);
        @(negedge Clk);
        bus.N     = n[W-1:0];
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        while (dones == 0 && cyc < bound) begin
            cyc++;
            case (mode)
                0:       bus.Ready = 1'b1;
                1:       bus.Ready = ($urandom_range(0, 2) != 0);
                default: bus.Ready = (hold >= 20);
            endcase
            if (cyc == restart_at) begin
                bus.N     = 8'd50;
                bus.Start = 1'b1;
            end else begin
                bus.Start = 1'b0;
            end
            if (bus.Valid) begin
                seen_valid = 1;
                if (mode == 2 && hold < 20) begin
                    if (hold > 0 && bus.Prime !== held) unstable++;
                    held = bus.Prime;
                    hold++;
                end
            end
            if (bus.Valid && bus.Ready) begin
                got.push_back(int'(bus.Prime));
                if (int'(bus.Prime) > max_seen) max_seen = int'(bus.Prime);
            end
            if (bus.Done) dones++;
            if (dones == 0) @(negedge Clk);
        end
        bus.Start = 1'b0;
        check({tag, "_done"}, dones, 1);
        if (n < 2) begin
            check({tag, "_valid_never"}, seen_valid, 0);
            check({tag, "_done_lat_le3"}, (cyc <= 3), 1);
        end
        if (mode == 2) begin
            check({tag, "_hold_unstable"}, unstable, 0);
            check({tag, "_hold_prime"}, held, 2);
            check({tag, "_hold_cycles"}, hold, 20);
        end
        check({tag, "_nprimes"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check({tag, "_prime"}, got[i], exp_q[i]);
        if (got.size() > 0)
            check({tag, "_last"}, got[got.size()-1], exp_q[exp_q.size()-1]);
        check({tag, "_max_le_n"}, (max_seen <= n), 1);
        @(negedge Clk);
        check({tag, "_busy_after"}, bus.Busy, 0);
        check({tag, "_done_1cyc"}, bus.Done, 0);
        check({tag, "_count"}, bus.Count, exp_q.size());
    endtask

    initial begin
        int n;
        int dones;
        int waited;
        bus.N     = '0;
        bus.Start = 1'b0;
        bus.Ready = 1'b0;
        #2;
        check("rst_prime", bus.Prime, 0);
        check("rst_valid", bus.Valid, 0);
        check("rst_busy",  bus.Busy, 0);
        check("rst_done",  bus.Done, 0);
        check("rst_count", bus.Count, 0);
        @(negedge Clk);
        Rst_n = 1'b1;

        run(10, 0, 0, 2000, "n10");
        run(1, 0, 0, 20, "n1");
        run(0, 0, 0, 20, "n0");
        run(13, 2, 0, 4000, "n13_stall");
        run(20, 0, 10, 8000, "restart");
        run(255, 0, 0, 90000, "n255");

        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(0, 40);
            run(n, 1, 0, 12000, "rand");
        end

        // asynchronous reset while a prime is waiting
        @(negedge Clk);
        bus.N     = 8'd20;
        bus.Start = 1'b1;
        bus.Ready = 1'b0;
        @(negedge Clk);
        bus.Start = 1'b0;
        waited = 0;
        while (!bus.Valid && waited < 500) begin
            @(negedge Clk);
            waited++;
        end
        check("rst_mid_valid_seen", bus.Valid, 1);
        Rst_n = 1'b0;
        #1;
        check("rst_mid_valid", bus.Valid, 0);
        check("rst_mid_busy",  bus.Busy, 0);
        check("rst_mid_prime", bus.Prime, 0);
        check("rst_mid_count", bus.Count, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (bus.Done) dones++;
        end
        check("rst_mid_no_done", dones, 0);
        check("rst_mid_idle", bus.Busy, 0);
        run(7, 0, 0, 2000, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
